// File: rtl/config_ctrl_pkg.sv
// Shared definitions for the credit-aware leaf configuration controller.
// Holds the default sizing parameters, the two fifo_addr command codes and
// the helper functions that size the packed per-channel slices of
// control_reg. Field offsets inside a packet are derived from these sizes by
// the blocks that import this package.
package config_ctrl_pkg;

  localparam int DEF_PACKET_BITS   = 97;
  localparam int DEF_LEAF_BITS     = 6;
  localparam int DEF_PORT_BITS     = 4;
  localparam int DEF_ADDR_BITS     = 7;
  localparam int DEF_PAYLOAD_BITS  = 64;
  localparam int DEF_FS_BITS       = 8;
  localparam int DEF_FS_RESET      = 127;
  localparam int DEF_CREDIT_BITS   = 4;

  // fifo_addr values that turn a port-0 packet into a command
  localparam int DEF_DONE_CODE     = 4;
  localparam int DEF_READBACK_CODE = 5;

  // Input channel slice: {src_leaf, src_port}
  function automatic int inSliceWidth(input int leafBits, input int portBits);
    return leafBits + portBits;
  endfunction

  // Output channel slice: {update, dst_leaf, dst_port, bram_addr, credit}
  function automatic int outSliceWidth(input int leafBits, input int portBits,
                                       input int addrBits, input int fsBits);
    return 1 + leafBits + portBits + addrBits + fsBits;
  endfunction

endpackage

// File: rtl/config_ctrl_credit_counter.sv
// Free-space credit counter for one output channel.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   load_i             config load; overrides add/consume this cycle
//   loadValue_i        credit value to load
//   add_i              credits returned this cycle
//   consume_i          one word sent this cycle
//   credit_o           registered credit
//   creditNext_o       credit that will be registered at the next edge
//   underflow_o        strobe: consume would drive the count below zero
//   overflow_o         strobe: the count would exceed the maximum
module credit_counter #(
  parameter int FS_BITS     = 8,
  parameter int FS_RESET    = 127,
  parameter int CREDIT_BITS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [FS_BITS-1:0]     loadValue_i,
  input  logic [CREDIT_BITS-1:0] add_i,
  input  logic                   consume_i,
  output logic [FS_BITS-1:0]     credit_o,
  output logic [FS_BITS-1:0]     creditNext_o,
  output logic                   underflow_o,
  output logic                   overflow_o
);

  // Two guard bits: one for the carry of add, one for the sign of consume.
  localparam int SUM_BITS = FS_BITS + 2;
  localparam logic signed [SUM_BITS-1:0] FS_MAX = SUM_BITS'((1 << FS_BITS) - 1);

  logic [FS_BITS-1:0]         credit_q;
  logic [FS_BITS-1:0]         credit_d;
  logic signed [SUM_BITS-1:0] sum;

  always_comb begin
    sum = $signed({2'b00, credit_q}) + $signed(SUM_BITS'(add_i))
        - $signed(SUM_BITS'(consume_i));
    credit_d    = credit_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    if (load_i) begin
      credit_d = loadValue_i;
    end else if (sum[SUM_BITS-1]) begin
      credit_d    = '0;
      underflow_o = 1'b1;
    end else if (sum > FS_MAX) begin
      credit_d   = '1;
      overflow_o = 1'b1;
    end else begin
      credit_d = sum[FS_BITS-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= FS_BITS'(FS_RESET);
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o     = credit_q;
  assign creditNext_o = credit_d;

endmodule

// File: rtl/config_ctrl_credit.sv
// Leaf configuration controller with built-in output credit counters and a
// readback path.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   configure_in_i                 config packet, valid when MSB set
//   out_consume_i                  per output channel: one word sent
//   control_reg_o                  packed channel config, inputs in low bits
//   credit_avail_o                 per output channel: credit != 0
//   is_done_o                      one-cycle done pulse
//   self_leaf_reg_o                latched own leaf id
//   self_leaf_reg_src_send_o       CDC send request for self_leaf_reg
//   self_leaf_reg_src_rcv_i        CDC acknowledge
//   resp_packet_o, resp_valid_o    readback response (valid/ready)
//   resp_ready_i
//   err_flags_o                    sticky {readback dropped, saturated, underflow}
module config_ctrl_credit
  import config_ctrl_pkg::*;
#(
  parameter int PACKET_BITS   = DEF_PACKET_BITS,
  parameter int NUM_LEAF_BITS = DEF_LEAF_BITS,
  parameter int NUM_PORT_BITS = DEF_PORT_BITS,
  parameter int NUM_ADDR_BITS = DEF_ADDR_BITS,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int IN_PORT_BASE  = 2,
  parameter int OUT_PORT_BASE = 9,
  parameter int FS_BITS       = DEF_FS_BITS,
  parameter int FS_RESET      = DEF_FS_RESET,
  parameter int CREDIT_BITS   = DEF_CREDIT_BITS,
  parameter int DONE_CODE     = DEF_DONE_CODE,
  parameter int READBACK_CODE = DEF_READBACK_CODE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PACKET_BITS-1:0]   configure_in_i,
  input  logic [NUM_OUT_PORTS-1:0] out_consume_i,
  output logic [NUM_IN_PORTS*inSliceWidth(NUM_LEAF_BITS, NUM_PORT_BITS)
                + NUM_OUT_PORTS*outSliceWidth(NUM_LEAF_BITS, NUM_PORT_BITS,
                                              NUM_ADDR_BITS, FS_BITS)-1:0] control_reg_o,
  output logic [NUM_OUT_PORTS-1:0] credit_avail_o,
  output logic                     is_done_o,
  output logic [NUM_LEAF_BITS-1:0] self_leaf_reg_o,
  output logic                     self_leaf_reg_src_send_o,
  input  logic                     self_leaf_reg_src_rcv_i,
  output logic [PACKET_BITS-1:0]   resp_packet_o,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [2:0]               err_flags_o
);

  localparam int IN_W       = inSliceWidth(NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int OUT_W      = outSliceWidth(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, FS_BITS);
  localparam int IN_TOTAL   = NUM_IN_PORTS * IN_W;
  localparam int LEAF_LSB   = PACKET_BITS - 1 - NUM_LEAF_BITS;
  localparam int PORT_LSB   = LEAF_LSB - NUM_PORT_BITS;
  localparam int FIFO_BITS  = PORT_LSB - PAYLOAD_BITS;
  localparam int SELF_LSB   = PAYLOAD_BITS - NUM_PORT_BITS;
  localparam int DSLEAF_LSB = SELF_LSB - NUM_LEAF_BITS;
  localparam int DSPORT_LSB = DSLEAF_LSB - NUM_PORT_BITS;
  localparam int ADDR_LSB   = DSPORT_LSB - NUM_ADDR_BITS;
  localparam int FS_LSB     = ADDR_LSB - FS_BITS;

  logic                     cfgValid;
  logic [NUM_LEAF_BITS-1:0] cfgLeaf;
  logic [NUM_PORT_BITS-1:0] cfgPort;
  logic [FIFO_BITS-1:0]     cfgFifo;
  logic [PAYLOAD_BITS-1:0]  payload;
  logic [NUM_PORT_BITS-1:0] selfPort;
  logic [NUM_LEAF_BITS-1:0] dsLeaf;
  logic [NUM_PORT_BITS-1:0] dsPort;
  logic [NUM_ADDR_BITS-1:0] bramAddr;
  logic [FS_BITS-1:0]       freeSpace;
  logic [CREDIT_BITS-1:0]   creditAdd;
  logic                     unusedPayload;

  assign cfgValid  = configure_in_i[PACKET_BITS-1];
  assign cfgLeaf   = configure_in_i[LEAF_LSB +: NUM_LEAF_BITS];
  assign cfgPort   = configure_in_i[PORT_LSB +: NUM_PORT_BITS];
  assign cfgFifo   = configure_in_i[PAYLOAD_BITS +: FIFO_BITS];
  assign payload   = configure_in_i[PAYLOAD_BITS-1:0];
  assign selfPort  = payload[SELF_LSB +: NUM_PORT_BITS];
  assign dsLeaf    = payload[DSLEAF_LSB +: NUM_LEAF_BITS];
  assign dsPort    = payload[DSPORT_LSB +: NUM_PORT_BITS];
  assign bramAddr  = payload[ADDR_LSB +: NUM_ADDR_BITS];
  assign freeSpace = payload[FS_LSB +: FS_BITS];
  assign creditAdd = payload[CREDIT_BITS-1:0];
  // Padding bits of the payload carry no information.
  assign unusedPayload = ^payload;

  // Done and readback are commands, not channel configs or self-leaf updates.
  logic isCtrl, isDone, isReadback, isOutCfg, isInCfg, isLatch;
  assign isCtrl     = cfgValid && (cfgPort == '0);
  assign isDone     = isCtrl && (cfgFifo == FIFO_BITS'(DONE_CODE));
  assign isReadback = isCtrl && (cfgFifo == FIFO_BITS'(READBACK_CODE));
  assign isOutCfg   = isCtrl && !isDone && !isReadback;
  assign isLatch    = isOutCfg;
  assign isInCfg    = cfgValid && (cfgPort == NUM_PORT_BITS'(1));

  // One-hot channel selects; ids outside the channel ranges match nothing.
  logic [NUM_IN_PORTS-1:0]  inSel;
  logic [NUM_OUT_PORTS-1:0] outSel, retSel, outLoad;
  always_comb begin
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      inSel[i] = (selfPort == NUM_PORT_BITS'(IN_PORT_BASE + i));
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      outSel[k]  = (selfPort == NUM_PORT_BITS'(OUT_PORT_BASE + k));
      retSel[k]  = cfgValid && (cfgPort == NUM_PORT_BITS'(OUT_PORT_BASE + k));
      outLoad[k] = isOutCfg && outSel[k];
    end
  end

  logic [NUM_LEAF_BITS-1:0] srcLeaf_q [NUM_IN_PORTS];
  logic [NUM_LEAF_BITS-1:0] srcLeaf_d [NUM_IN_PORTS];
  logic [NUM_PORT_BITS-1:0] srcPort_q [NUM_IN_PORTS];
  logic [NUM_PORT_BITS-1:0] srcPort_d [NUM_IN_PORTS];
  logic [NUM_LEAF_BITS-1:0] dstLeaf_q [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] dstLeaf_d [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dstPort_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dstPort_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d    [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] update_q;

  always_comb begin
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      srcLeaf_d[i] = srcLeaf_q[i];
      srcPort_d[i] = srcPort_q[i];
      if (isInCfg && inSel[i]) begin
        srcLeaf_d[i] = dsLeaf;
        srcPort_d[i] = dsPort;
      end
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      dstLeaf_d[k] = dstLeaf_q[k];
      dstPort_d[k] = dstPort_q[k];
      addr_d[k]    = addr_q[k];
      if (outLoad[k]) begin
        dstLeaf_d[k] = dsLeaf;
        dstPort_d[k] = dsPort;
        addr_d[k]    = bramAddr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        srcLeaf_q[i] <= '0;
        srcPort_q[i] <= NUM_PORT_BITS'(OUT_PORT_BASE);
      end
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        dstLeaf_q[k] <= '0;
        dstPort_q[k] <= NUM_PORT_BITS'(IN_PORT_BASE);
        addr_q[k]    <= '0;
      end
      update_q <= '0;
    end else begin
      srcLeaf_q <= srcLeaf_d;
      srcPort_q <= srcPort_d;
      dstLeaf_q <= dstLeaf_d;
      dstPort_q <= dstPort_d;
      addr_q    <= addr_d;
      update_q  <= outLoad;
    end
  end

  logic [FS_BITS-1:0]       credit     [NUM_OUT_PORTS];
  logic [FS_BITS-1:0]       creditNext [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] underflow, overflow;

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : gCredit
    credit_counter #(
      .FS_BITS    (FS_BITS),
      .FS_RESET   (FS_RESET),
      .CREDIT_BITS(CREDIT_BITS)
    ) uCredit (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (outLoad[k]),
      .loadValue_i (freeSpace),
      .add_i       (retSel[k] ? creditAdd : '0),
      .consume_i   (out_consume_i[k]),
      .credit_o    (credit[k]),
      .creditNext_o(creditNext[k]),
      .underflow_o (underflow[k]),
      .overflow_o  (overflow[k])
    );
  end

  always_comb begin
    control_reg_o = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      control_reg_o[i*IN_W +: IN_W] = {srcLeaf_q[i], srcPort_q[i]};
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      control_reg_o[IN_TOTAL + k*OUT_W +: OUT_W] =
        {update_q[k], dstLeaf_q[k], dstPort_q[k], addr_q[k], credit[k]};
      credit_avail_o[k] = (credit[k] != '0);
    end
  end

  // Self-leaf latch and CDC request; a new latch takes priority over rcv.
  logic [NUM_LEAF_BITS-1:0] selfLeaf_q;
  logic                     srcSend_q, isDone_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      selfLeaf_q <= '0;
      srcSend_q  <= 1'b0;
      isDone_q   <= 1'b0;
    end else begin
      isDone_q <= isDone;
      if (isLatch) begin
        selfLeaf_q <= cfgLeaf;
        srcSend_q  <= 1'b1;
      end else if (self_leaf_reg_src_rcv_i) begin
        srcSend_q <= 1'b0;
      end
    end
  end

  // Readback response; output credit reflects this cycle's update.
  logic [PAYLOAD_BITS-1:0]  rbPayload;
  logic [PACKET_BITS-1:0]   respPacket_d, respPacket_q;
  logic                     respValid_q, rbHit, respAccept, respDrop;
  always_comb begin
    rbPayload = '0;
    rbPayload[SELF_LSB +: NUM_PORT_BITS] = selfPort;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (inSel[i]) begin
        rbPayload[DSLEAF_LSB +: NUM_LEAF_BITS] = srcLeaf_q[i];
        rbPayload[DSPORT_LSB +: NUM_PORT_BITS] = srcPort_q[i];
      end
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      if (outSel[k]) begin
        rbPayload[DSLEAF_LSB +: NUM_LEAF_BITS] = dstLeaf_q[k];
        rbPayload[DSPORT_LSB +: NUM_PORT_BITS] = dstPort_q[k];
        rbPayload[ADDR_LSB +: NUM_ADDR_BITS]   = addr_q[k];
        rbPayload[FS_LSB +: FS_BITS]           = creditNext[k];
      end
    end
    respPacket_d = {1'b1, selfLeaf_q, {NUM_PORT_BITS{1'b0}},
                    FIFO_BITS'(READBACK_CODE), rbPayload};
  end

  // A full buffer that is draining this cycle can take the new response.
  assign rbHit      = isReadback && ((|inSel) || (|outSel));
  assign respAccept = rbHit && (!respValid_q || resp_ready_i);
  assign respDrop   = rbHit && respValid_q && !resp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      respValid_q  <= 1'b0;
      respPacket_q <= '0;
    end else if (respAccept) begin
      respValid_q  <= 1'b1;
      respPacket_q <= respPacket_d;
    end else if (respValid_q && resp_ready_i) begin
      respValid_q <= 1'b0;
    end
  end

  logic [2:0] errFlags_q, errFlags_d;
  assign errFlags_d = errFlags_q | {respDrop, |overflow, |underflow};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      errFlags_q <= '0;
    end else begin
      errFlags_q <= errFlags_d;
    end
  end

  assign is_done_o                = isDone_q;
  assign self_leaf_reg_o          = selfLeaf_q;
  assign self_leaf_reg_src_send_o = srcSend_q;
  assign resp_packet_o            = respPacket_q;
  assign resp_valid_o             = respValid_q;
  assign err_flags_o              = errFlags_q;

endmodule
